truth_table_sweep: RTL and testbench
====================================

TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 Parameter SETTLE_CYCLES, default 4: cycles each input row is held before its output is sampled; legal range 1..255.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 start  input  1  single-cycle request to begin a sweep.
REQ-006 abort  input  1  terminate the sweep in progress.
REQ-007 dut_out  input  1  output of the 3-input logic gate under test.
REQ-008 expected_code  input  8  expected truth-table code; used only when compare is compiled in.
REQ-009 in1, in2, in3  output  1 each  drive the gate under test; row index r = {in1,in2,in3}.
REQ-010 busy  output  1  sweep in progress.
REQ-011 done  output  1  one-cycle pulse when a sweep completes.
REQ-012 table_code  output  8  last completed truth-table code.
REQ-013 mismatch  output  1  last completed code differs from the expected code.

Function
REQ-014 FSM states: IDLE, SWEEP.
- IDLE->SWEEP on an edge with start=1 and abort=0.
- SWEEP->IDLE after the row-7 capture, or on an edge with abort=1.
REQ-015 In IDLE: in1/in2/in3 = 000 and busy = 0.
REQ-016 Sweep entry:
- At the accepting edge, r = 0 and the settle counter = 0.
- Rows are driven from the following cycle, with busy = 1.
REQ-017 Each row r SHALL be held for exactly SETTLE_CYCLES cycles.
REQ-018 dut_out SHALL be captured into scratch bit [7-r] on the edge that ends the row's hold window; r increments on that same edge.
- Bit 7 = row 000 and bit 0 = row 111, so the gate with rows 011 and 101 high gives 0x14.
REQ-019 Completion: on the row-7 capture edge the block SHALL:
- load table_code with the scratch register, including the row-7 bit;
- return to IDLE;
- drive done = 1 for exactly the next cycle.
REQ-020 Sweep latency: 8*SETTLE_CYCLES busy cycles. done is high in the cycle immediately after the last busy cycle.
REQ-021 table_code and mismatch SHALL change only at completion and hold otherwise.
REQ-022 start while busy SHALL be ignored.
REQ-023 start during the done cycle (IDLE) SHALL be accepted, giving back-to-back sweeps.
REQ-024 Abort while busy:
- next cycle is IDLE with inputs 000;
- done is not pulsed;
- table_code and mismatch are unchanged;
- scratch data is discarded.
REQ-025 start and abort asserted together in IDLE: abort SHALL win and the block stays in IDLE.
REQ-026 abort on the row-7 capture edge SHALL win: no done pulse and table_code is unchanged.
REQ-027 The settle counter SHALL be 8 bits wide and SHALL NOT wrap within a row.

Reset
REQ-028 While rst_n = 0 at a clock edge, the block SHALL go to IDLE with these values:
- in1/in2/in3 = 000;
- busy = 0, done = 0;
- table_code = 0x00, mismatch = 0;
- scratch, row and settle counters = 0.
REQ-029 Reset mid-sweep SHALL abandon the sweep with no done pulse.
REQ-030 Reset SHALL take priority over start and abort.

Configuration
REQ-031 Macro TT_SWEEP_COMPARE_EN defined:
- expected_code is registered at the start-accepting edge;
- at completion, mismatch = (captured code != registered expected code), updated together with table_code.
REQ-032 Macro TT_SWEEP_COMPARE_EN undefined:
- mismatch is constant 0 and expected_code is ignored;
- no compare registers are present;
- all other behaviour is identical.

Verification
REQ-033 SETTLE_CYCLES=4, dut_out modelled as the 0x14 gate, start pulse:
- busy high for 32 cycles;
- done one cycle later;
- table_code=0x14;
- input rows observed in order 000..111, each for 4 cycles.
REQ-034 dut_out tied 1, then a second sweep with dut_out tied 0 started in the done cycle -> table_code=0xFF, then 0x00; the second sweep starts with no idle gap.
REQ-035 A sweep completes with 0x14, then a new sweep is aborted while r=3:
- inputs are 000 on the next cycle, busy=0;
- no done pulse;
- table_code stays 0x14.
REQ-036 rst_n low for one edge during row 5 -> all outputs equal their reset values (REQ-028) on the next cycle; a later start performs a full clean sweep.
REQ-037 With TT_SWEEP_COMPARE_EN defined, expected_code=0x14:
- gate modelled as 0x16 -> mismatch=1 at done;
- gate modelled as 0x14 -> mismatch=0;
- expected_code changed mid-sweep has no effect.
REQ-038 start re-pulsed while busy and start+abort asserted together in IDLE -> no restart, no state change, sweep timing per REQ-033.

Source files
------------

// File: rtl/truth_table_sweep.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | truth_table_sweep: drives all 8 rows of a 3-input gate, captures its     |
// | truth table as an 8-bit code. TT_SWEEP_COMPARE_EN adds expected check.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module truth_table_sweep #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       dut_out,
   input  logic [7:0] expected_code,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   output logic       busy,
   output logic       done,
   output logic [7:0] table_code,
   output logic       mismatch
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [2:0] row_q, row_d;
   logic [7:0] settle_q, settle_d;
   logic [7:0] scratch_q, scratch_d;
   logic [7:0] table_code_q, table_code_d;
   logic       done_q, done_d;
   logic [7:0] captured_code;

`ifdef TT_SWEEP_COMPARE_EN
   logic [7:0] exp_q, exp_d;
   logic       mismatch_q, mismatch_d;
`else
   logic       unused_expected;
   assign unused_expected = ^expected_code;
`endif

   // Row 7 lands in bit 0, so the final code is the scratch plus the live sample.
   assign captured_code = {scratch_q[7:1], dut_out};

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      settle_d     = settle_q;
      scratch_d    = scratch_q;
      table_code_d = table_code_q;
      done_d       = 1'b0;
`ifdef TT_SWEEP_COMPARE_EN
      exp_d        = exp_q;
      mismatch_d   = mismatch_q;
`endif
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d   = SWEEP;
               row_d     = 3'd0;
               settle_d  = 8'd0;
               scratch_d = 8'd0;
`ifdef TT_SWEEP_COMPARE_EN
               exp_d     = expected_code;
`endif
            end
         end
         SWEEP: begin
            if (abort) begin
               state_d   = IDLE;
               row_d     = 3'd0;
               settle_d  = 8'd0;
               scratch_d = 8'd0;
            end else if (settle_q == SETTLE_LAST) begin
               settle_d = 8'd0;
               if (row_q == 3'd7) begin
                  state_d      = IDLE;
                  row_d        = 3'd0;
                  scratch_d    = 8'd0;
                  table_code_d = captured_code;
                  done_d       = 1'b1;
`ifdef TT_SWEEP_COMPARE_EN
                  mismatch_d   = (captured_code != exp_q);
`endif
               end else begin
                  scratch_d[~row_q] = dut_out;
                  row_d             = row_q + 3'd1;
               end
            end else begin
               settle_d = settle_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         row_q        <= 3'd0;
         settle_q     <= 8'd0;
         scratch_q    <= 8'd0;
         table_code_q <= 8'd0;
         done_q       <= 1'b0;
`ifdef TT_SWEEP_COMPARE_EN
         exp_q        <= 8'd0;
         mismatch_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         settle_q     <= settle_d;
         scratch_q    <= scratch_d;
         table_code_q <= table_code_d;
         done_q       <= done_d;
`ifdef TT_SWEEP_COMPARE_EN
         exp_q        <= exp_d;
         mismatch_q   <= mismatch_d;
`endif
      end
   end

   assign {in1, in2, in3} = (state_q == SWEEP) ? row_q : 3'b000;
   assign busy            = (state_q == SWEEP);
   assign done            = done_q;
   assign table_code      = table_code_q;
`ifdef TT_SWEEP_COMPARE_EN
   assign mismatch        = mismatch_q;
`else
   assign mismatch        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweep.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_truth_table_sweep: directed self-checking bench for truth_table_sweep |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_truth_table_sweep;

`ifdef TT_SWEEP_COMPARE_EN
   localparam bit CMP = 1'b1;
`else
   localparam bit CMP = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic       dut_out;
   logic [7:0] expected_code;
   logic       in1, in2, in3;
   logic       busy;
   logic       done;
   logic [7:0] table_code;
   logic       mismatch;
   logic [7:0] gate_code;
   logic [2:0] row;

   int checks;
   int errors;

   truth_table_sweep #(.SETTLE_CYCLES(4)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .dut_out      (dut_out),
      .expected_code(expected_code),
      .in1          (in1),
      .in2          (in2),
      .in3          (in3),
      .busy         (busy),
      .done         (done),
      .table_code   (table_code),
      .mismatch     (mismatch)
   );

   // Gate model: row r drives code bit [7-r]
   assign row     = {in1, in2, in3};
   assign dut_out = gate_code[~row];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic kick();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rows"}, 32'(row), 32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
      check({tag, "_done"}, 32'(done), 32'h0);
      check({tag, "_code"}, 32'(table_code), 32'h00);
      check({tag, "_mis"}, 32'(mismatch), 32'h0);
   endtask

   // Entered in the first busy cycle (one step after the accepting edge).
   task automatic sweep_body(input string tag, input logic [7:0] code, input bit mis,
                             input int restart_at, input bit chain, input logic [7:0] next_code);
      for (int i = 0; i < 32; i++) begin
         check({tag, "_busy"}, 32'(busy), 32'h1);
         check({tag, "_row"}, 32'(row), 32'(i / 4));
         check({tag, "_nodone"}, 32'(done), 32'h0);
         if (i == restart_at) start = 1'b1;
         else if (i == restart_at + 1) start = 1'b0;
         step();
      end
      check({tag, "_endbusy"}, 32'(busy), 32'h0);
      check({tag, "_done"}, 32'(done), 32'h1);
      check({tag, "_code"}, 32'(table_code), 32'(code));
      check({tag, "_mis"}, 32'(mismatch), 32'(mis));
      check({tag, "_idlerows"}, 32'(row), 32'h0);
      if (chain) begin
         start     = 1'b1;
         gate_code = next_code;
         step();
         start     = 1'b0;
         check({tag, "_nogap"}, 32'(busy), 32'h1);
      end else begin
         step();
         check({tag, "_done1cyc"}, 32'(done), 32'h0);
         check({tag, "_idle"}, 32'(busy), 32'h0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      start         = 1'b0;
      abort         = 1'b0;
      gate_code     = 8'h00;
      expected_code = 8'h14;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_reset_vals("rst");

      // Basic 0x14 sweep with a start re-pulse while busy
      gate_code = 8'h14;
      kick();
      sweep_body("sw14", 8'h14, 1'b0, 10, 1'b0, 8'h00);

      // start and abort together in IDLE: abort wins
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      check("sa_busy", 32'(busy), 32'h0);
      check("sa_rows", 32'(row), 32'h0);
      check("sa_code", 32'(table_code), 32'h14);
      step();
      check("sa_busy2", 32'(busy), 32'h0);

      // Back-to-back: all-ones then all-zeros, second started in done cycle
      gate_code = 8'hFF;
      kick();
      sweep_body("swff", 8'hFF, CMP, -1, 1'b1, 8'h00);
      sweep_body("sw00", 8'h00, CMP, -1, 1'b0, 8'h00);

      // Complete 0x14, then abort a new sweep in row 3
      gate_code = 8'h14;
      kick();
      sweep_body("sw14b", 8'h14, 1'b0, -1, 1'b0, 8'h00);
      gate_code = 8'hFF;
      kick();
      repeat (13) step();
      check("ab3_row", 32'(row), 32'h3);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("ab3_rows", 32'(row), 32'h0);
      check("ab3_busy", 32'(busy), 32'h0);
      check("ab3_done", 32'(done), 32'h0);
      check("ab3_code", 32'(table_code), 32'h14);
      step();
      check("ab3_done2", 32'(done), 32'h0);

      // Abort exactly on the row-7 capture edge
      kick();
      repeat (31) step();
      check("ab7_row", 32'(row), 32'h7);
      check("ab7_busy", 32'(busy), 32'h1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("ab7_done", 32'(done), 32'h0);
      check("ab7_busy0", 32'(busy), 32'h0);
      check("ab7_code", 32'(table_code), 32'h14);
      step();
      check("ab7_done2", 32'(done), 32'h0);

      // Reset during row 5, then a clean sweep
      kick();
      repeat (21) step();
      check("rs5_row", 32'(row), 32'h5);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_reset_vals("rs5");
      step();
      check("rs5_done", 32'(done), 32'h0);
      gate_code = 8'h14;
      kick();
      sweep_body("swrs", 8'h14, 1'b0, -1, 1'b0, 8'h00);

`ifdef TT_SWEEP_COMPARE_EN
      expected_code = 8'h14;
      gate_code     = 8'h16;
      kick();
      sweep_body("cmp16", 8'h16, 1'b1, -1, 1'b0, 8'h00);
      gate_code = 8'h14;
      kick();
      sweep_body("cmp14", 8'h14, 1'b0, -1, 1'b0, 8'h00);
      gate_code = 8'h16;
      kick();
      expected_code = 8'h16;
      sweep_body("cmpmid", 8'h16, 1'b1, -1, 1'b0, 8'h00);
      expected_code = 8'h14;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
